hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline control unit for the 5-stage core: each cycle it drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch flushes and variable-latency data-memory waits, with a timeout watchdog. It also keeps saturating stall/flush statistics counters for the lab bench.

## Interface

**Parameters**
- `TIMEOUT`, default 64: maximum number of consecutive MEM_WAIT cycles before the unit halts.
- `CNT_W`, default 16: width of the statistics counters.

**Ports**
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `ifid_rs_i` input 5: rs field of the instruction in IF/ID.
- `ifid_rt_i` input 5: rt field of the instruction in IF/ID.
- `idex_memread_i` input 1: instruction in ID/EX is a load.
- `idex_rt_i` input 5: destination register of the instruction in ID/EX.
- `branch_taken_i` input 1: branch in EX resolved taken; PC target is valid.
- `mem_req_i` input 1: instruction in MEM accesses data memory.
- `mem_ready_i` input 1: data memory completes the access this cycle.
- `pc_write_o` output 1: PC update enable.
- `ifid_write_o` output 1: IF/ID write enable.
- `ifid_flush_o` output 1: IF/ID clear.
- `idex_write_o` output 1: ID/EX write enable.
- `idex_flush_o` output 1: ID/EX clear (bubble).
- `exmem_write_o` output 1: EX/MEM write enable.
- `err_o` output 1: sticky watchdog timeout flag.
- `lu_stall_cnt_o` output CNT_W: number of load-use stall cycles.
- `mem_stall_cnt_o` output CNT_W: number of freeze cycles.
- `flush_cnt_o` output CNT_W: number of branch flushes.

## Operation

**States**
- RUN: normal operation.
- MEM_WAIT: memory access outstanding.
- HALT: watchdog expired.

**Control outputs** are a combinational decode of the current state and inputs. Priority, highest first:
1. Reset (`rst_i` = 1):
   - All write enables are 0.
   - `ifid_flush_o` = 1 and `idex_flush_o` = 1.
2. Freeze, which applies in either of these cases:
   - State is HALT.
   - State is MEM_WAIT and `mem_ready_i` = 0.
   - State is RUN and `mem_req_i` = 1 and `mem_ready_i` = 0.

   During freeze all write enables are 0 and all flushes are 0.
3. Branch (`branch_taken_i` = 1):
   - `pc_write_o`, `ifid_write_o`, `idex_write_o` and `exmem_write_o` are 1.
   - `ifid_flush_o` = 1 and `idex_flush_o` = 1.
4. Load-use, when `idex_memread_i` = 1, `idex_rt_i` ≠ 0, and `idex_rt_i` equals `ifid_rs_i` or `ifid_rt_i`:
   - `pc_write_o` = 0 and `ifid_write_o` = 0.
   - `idex_flush_o` = 1.
   - `idex_write_o` = 1 and `exmem_write_o` = 1.
5. Default: all write enables are 1 and all flushes are 0.

**Transitions**
- RUN → MEM_WAIT when `mem_req_i` = 1 and `mem_ready_i` = 0.
- MEM_WAIT → RUN when `mem_ready_i` = 1. That cycle decodes with RUN priorities 3–5, so a branch held frozen in EX takes effect on the exit cycle.
- MEM_WAIT → HALT when the wait counter reaches TIMEOUT−1 with `mem_ready_i` = 0. `err_o` is set on the same edge.
- HALT persists until reset.

**Wait counter**
- Cleared on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle.
- Width is clog2(TIMEOUT).

**Statistics counters**
- Each saturates at 2^CNT_W − 1.
- `lu_stall_cnt_o` increments on each cycle where priority 4 is selected.
- `mem_stall_cnt_o` increments on each freeze cycle, including HALT.
- `flush_cnt_o` increments on each cycle where priority 3 is selected.

## Timing

- All control outputs respond in zero cycles (same cycle as the inputs); state, counters and `err_o` update on the next rising edge.
- Reset values: state RUN, all counters 0, `err_o` 0.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load has moved to EX/MEM, so the compare fails.
- Memory freeze lasts N cycles for N cycles of `mem_ready_i` low. The access counts as a single stall episode.
- Freeze entered from RUN also counts its first cycle in `mem_stall_cnt_o`.
- Reset asserted during MEM_WAIT or HALT: the next state is RUN, and counters and `err_o` are cleared.
- Branch and load-use in the same cycle: the branch wins and the load-use counter does not increment.
- `mem_ready_i` = 1 without `mem_req_i`: ignored in RUN.
- `err_o` is cleared only by reset.

## Structure

- Package `hazard_pkg`:
  - State enum: RUN, MEM_WAIT, HALT.
  - `REG_ZERO` = 5'd0.
- Sub-module `sat_counter` (parameter W, inputs `inc` and `clr`), instantiated three times.

## Test plan

- **Load-use:** `idex_memread_i` = 1, `idex_rt_i` = 5, `ifid_rs_i` = 5 for one cycle → `pc_write_o` = 0, `ifid_write_o` = 0, `idex_flush_o` = 1 for that cycle only; `lu_stall_cnt_o` = 1.
- **Zero register:** same stimulus with `idex_rt_i` = 0 → no stall; all writes 1.
- **Memory wait:** `mem_req_i` = 1 with `mem_ready_i` low for 3 cycles then high → writes 0 for 3 cycles, 1 on the 4th; state returns to RUN; `mem_stall_cnt_o` = 3.
- **Branch during freeze:** `branch_taken_i` held through a 2-cycle wait → no flush while frozen; `ifid_flush_o` = `idex_flush_o` = 1 on the exit cycle; `flush_cnt_o` = 1.
- **Watchdog:** TIMEOUT = 4, `mem_ready_i` never asserted → `err_o` rises after 4 wait cycles; freeze holds; reset clears `err_o` and returns to RUN.
- **Saturation:** CNT_W = 2, 5 load-use stalls → `lu_stall_cnt_o` = 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load in ID/EX whose destination feeds either source of the instruction in IF/ID.
    // Register zero never carries a dependency.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] dst,
        input logic [4:0] src_rs,
        input logic [4:0] src_rt
    );
        return memread && (dst != REG_ZERO) && ((dst == src_rs) || (dst == src_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall/flush statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment; stick at all-ones once reached.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control unit: decodes write enables/flushes for PC, IF/ID, ID/EX and EX/MEM,
// tracks outstanding data-memory accesses with a watchdog, and keeps statistics.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_flush_o,
    output logic             exmem_write_o,
    output logic             err_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned        WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    logic freeze;
    logic load_use;
    logic sel_branch;
    logic sel_lu;

    // Freeze condition depends on where the memory access stands.
    always_comb begin
        freeze = 1'b1;
        unique case (state)
            RUN:      freeze = mem_req_i & ~mem_ready_i;
            MEM_WAIT: freeze = ~mem_ready_i;
            HALT:     freeze = 1'b1;
            default:  freeze = 1'b1;
        endcase
    end

    assign load_use   = load_use_hazard(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
    assign sel_branch = ~rst_i & ~freeze & branch_taken_i;
    assign sel_lu     = ~rst_i & ~freeze & ~branch_taken_i & load_use;

    // Priority decode of the pipeline register controls: reset, freeze, branch, load-use, default.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_write_o = 1'b1;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end else if (freeze) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_flush_o  = 1'b1;
        end
    end

    // Memory-wait FSM with watchdog; HALT is left only through reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req_i && !mem_ready_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= HALT;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    assign err_o = err_q;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk_i (clk_i),
        .inc   (sel_lu),
        .clr   (rst_i),
        .count (lu_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .clk_i (clk_i),
        .inc   (freeze),
        .clr   (rst_i),
        .count (mem_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .inc   (sel_branch),
        .clr   (rst_i),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios followed by random traffic,
// checked cycle by cycle against a behavioural model of the pipeline control rules.
module tb_hazard_sequencer;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_CNT_W   = 2;
    localparam int          CNT_MAX    = (1 << TB_CNT_W) - 1;

    // Control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write
    localparam logic [5:0] CTRL_RESET  = 6'b001010;
    localparam logic [5:0] CTRL_FREEZE = 6'b000000;
    localparam logic [5:0] CTRL_BRANCH = 6'b111111;
    localparam logic [5:0] CTRL_LU     = 6'b000111;
    localparam logic [5:0] CTRL_NORMAL = 6'b110101;

    typedef struct packed {
        logic [5:0]          ctrl;
        logic                chk_stats;
        logic                err;
        logic [TB_CNT_W-1:0] lu;
        logic [TB_CNT_W-1:0] mem;
        logic [TB_CNT_W-1:0] fl;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [4:0]          ifid_rs, ifid_rt, idex_rt;
    logic                idex_memread, branch_taken, mem_req, mem_ready;
    logic                pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
    logic                err;
    logic [TB_CNT_W-1:0] lu_cnt, mem_cnt, fl_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   running  = 1'b1;
    int   cycle_no = 0;

    // Behavioural model: access bookkeeping plus plain integer statistics
    bit m_known   = 1'b0;
    bit m_halted  = 1'b0;
    bit m_waiting = 1'b0;
    int m_waited  = 0;
    bit m_err     = 1'b0;
    int m_lu      = 0;
    int m_mem     = 0;
    int m_fl      = 0;

    hazard_sequencer #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ifid_rs_i       (ifid_rs),
        .ifid_rt_i       (ifid_rt),
        .idex_memread_i  (idex_memread),
        .idex_rt_i       (idex_rt),
        .branch_taken_i  (branch_taken),
        .mem_req_i       (mem_req),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .ifid_flush_o    (ifid_flush),
        .idex_write_o    (idex_write),
        .idex_flush_o    (idex_flush),
        .exmem_write_o   (exmem_write),
        .err_o           (err),
        .lu_stall_cnt_o  (lu_cnt),
        .mem_stall_cnt_o (mem_cnt),
        .flush_cnt_o     (fl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Apply one cycle of inputs, push the expected response, advance the model past the edge.
    task automatic step(input bit r, input bit [4:0] rs, input bit [4:0] rt, input bit mr,
                        input bit [4:0] drt, input bit br, input bit req, input bit rdy);
        exp_t e;
        bit   frozen;
        bit   hazard;
        @(posedge clk);
        #1;
        rst          = r;
        ifid_rs      = rs;
        ifid_rt      = rt;
        idex_memread = mr;
        idex_rt      = drt;
        branch_taken = br;
        mem_req      = req;
        mem_ready    = rdy;

        e.chk_stats = m_known;
        e.err       = m_err;
        e.lu        = TB_CNT_W'(m_lu);
        e.mem       = TB_CNT_W'(m_mem);
        e.fl        = TB_CNT_W'(m_fl);

        if (r) begin
            e.ctrl    = CTRL_RESET;
            m_known   = 1'b1;
            m_halted  = 1'b0;
            m_waiting = 1'b0;
            m_waited  = 0;
            m_err     = 1'b0;
            m_lu      = 0;
            m_mem     = 0;
            m_fl      = 0;
        end else begin
            frozen = m_halted || (m_waiting && !rdy) || (!m_waiting && req && !rdy);
            hazard = mr && (drt != 5'd0) && (drt == rs || drt == rt);
            if (frozen) begin
                e.ctrl = CTRL_FREEZE;
                m_mem  = sat_inc(m_mem);
            end else if (br) begin
                e.ctrl = CTRL_BRANCH;
                m_fl   = sat_inc(m_fl);
            end else if (hazard) begin
                e.ctrl = CTRL_LU;
                m_lu   = sat_inc(m_lu);
            end else begin
                e.ctrl = CTRL_NORMAL;
            end
            if (m_halted) begin
                m_halted = 1'b1;
            end else if (m_waiting) begin
                if (rdy) begin
                    m_waiting = 1'b0;
                end else if (m_waited + 1 == TB_TIMEOUT) begin
                    m_waiting = 1'b0;
                    m_halted  = 1'b1;
                    m_err     = 1'b1;
                end else begin
                    m_waited++;
                end
            end else if (req && !rdy) begin
                m_waiting = 1'b1;
                m_waited  = 0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (sb.size() == 0) begin
                if (running) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cycle_no);
                end
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write} !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl cycle %0d: got %b expected %b", cycle_no,
                             {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}, e.ctrl);
                end
                if (e.chk_stats) begin
                    n_checks++;
                    if ({err, lu_cnt, mem_cnt, fl_cnt} !== {e.err, e.lu, e.mem, e.fl}) begin
                        n_fail++;
                        $display("FAIL stats cycle %0d: got err=%b lu=%0d mem=%0d fl=%0d expected err=%b lu=%0d mem=%0d fl=%0d",
                                 cycle_no, err, lu_cnt, mem_cnt, fl_cnt, e.err, e.lu, e.mem, e.fl);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1; ifid_rs = '0; ifid_rt = '0; idex_memread = 1'b0; idex_rt = '0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs, then the following cycle no longer matches
        step(0, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        step(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        // load-use on rt
        step(0, 5'd9, 5'd6, 1, 5'd6, 0, 0, 0);
        // zero register never stalls
        step(0, 5'd0, 5'd7, 1, 5'd0, 0, 0, 0);
        step(0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        idle(1);

        // memory wait: three cycles low, ready on the fourth
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 1);
        idle(1);
        // ready without request in RUN is ignored
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1);

        // branch held through a two-cycle wait, taking effect on exit
        step(0, 5'd1, 5'd2, 0, 5'd3, 1, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 1, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 1, 1, 1);
        idle(1);
        // branch beats a simultaneous load-use
        step(0, 5'd4, 5'd2, 1, 5'd4, 1, 0, 0);
        idle(1);

        // watchdog: ready never arrives; HALT ignores ready and branch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 1, 1, 1);
        step(0, 5'd4, 5'd2, 1, 5'd4, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // reset in the middle of a wait
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // saturation: five load-use stalls on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(0, 5'd8, 5'd2, 1, 5'd8, 0, 0, 0);
            idle(1);
        end
        idle(1);

        // random traffic over a small register space so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 1) == 1));
        end

        running = 1'b0;
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
